// File: rtl/split2_if.sv
// rtl/split2_if.sv - paired-payload input stream and split A/B output streams
interface split2_if #(
    parameter int ADW = 24,
    parameter int BDW = 18
);
    logic [ADW-1:0] s_axis_atdata;
    logic [BDW-1:0] s_axis_btdata;
    logic           s_axis_tvalid;
    logic           s_axis_tready;

    logic [ADW-1:0] m_axis_atdata;
    logic           m_axis_atvalid;
    logic           m_axis_atready;

    logic [BDW-1:0] m_axis_btdata;
    logic           m_axis_btvalid;
    logic           m_axis_btready;

    // Producer of input beats and consumer of both output streams
    modport master (
        output s_axis_atdata, s_axis_btdata, s_axis_tvalid,
        input  s_axis_tready,
        input  m_axis_atdata, m_axis_atvalid,
        output m_axis_atready,
        input  m_axis_btdata, m_axis_btvalid,
        output m_axis_btready
    );

    // The fork itself
    modport slave (
        input  s_axis_atdata, s_axis_btdata, s_axis_tvalid,
        output s_axis_tready,
        output m_axis_atdata, m_axis_atvalid,
        input  m_axis_atready,
        output m_axis_btdata, m_axis_btvalid,
        input  m_axis_btready
    );
endinterface

// File: rtl/split2.sv
// rtl/split2.sv - stream fork of paired A/B beats into two FIFO-decoupled outputs; optional SPLIT2_STALL_CNT_EN stall counter
module split2 #(
    parameter int ADW   = 24,
    parameter int BDW   = 18,
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
`ifdef SPLIT2_STALL_CNT_EN
    output logic [31:0] stall_count,
`endif
    split2_if.slave     bus
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [ADW-1:0] mem_a_q [DEPTH];
    logic [BDW-1:0] mem_b_q [DEPTH];

    logic [AW-1:0] wr_ptr_a_q, wr_ptr_a_d;
    logic [AW-1:0] rd_ptr_a_q, rd_ptr_a_d;
    logic [CW-1:0] count_a_q,  count_a_d;
    logic [AW-1:0] wr_ptr_b_q, wr_ptr_b_d;
    logic [AW-1:0] rd_ptr_b_q, rd_ptr_b_d;
    logic [CW-1:0] count_b_q,  count_b_d;

    logic full_a, full_b, empty_a, empty_b;
    logic push, pop_a, pop_b;

    // Handshake decode; tready looks only at registered occupancy so a
    // pop in the same cycle never opens the input
    always_comb begin
        full_a  = (count_a_q == FULL_CNT);
        full_b  = (count_b_q == FULL_CNT);
        empty_a = (count_a_q == '0);
        empty_b = (count_b_q == '0);

        bus.s_axis_tready  = rst && !full_a && !full_b;
        bus.m_axis_atvalid = !empty_a;
        bus.m_axis_btvalid = !empty_b;
        bus.m_axis_atdata  = mem_a_q[rd_ptr_a_q];
        bus.m_axis_btdata  = mem_b_q[rd_ptr_b_q];

        push  = bus.s_axis_tvalid && bus.s_axis_tready;
        pop_a = bus.m_axis_atvalid && bus.m_axis_atready;
        pop_b = bus.m_axis_btvalid && bus.m_axis_btready;
    end

    // Next pointer and occupancy values for both FIFOs
    always_comb begin
        wr_ptr_a_d = wr_ptr_a_q;
        rd_ptr_a_d = rd_ptr_a_q;
        count_a_d  = count_a_q;
        wr_ptr_b_d = wr_ptr_b_q;
        rd_ptr_b_d = rd_ptr_b_q;
        count_b_d  = count_b_q;

        if (push) begin
            wr_ptr_a_d = wr_ptr_a_q + AW'(1);
            wr_ptr_b_d = wr_ptr_b_q + AW'(1);
        end
        if (pop_a) rd_ptr_a_d = rd_ptr_a_q + AW'(1);
        if (pop_b) rd_ptr_b_d = rd_ptr_b_q + AW'(1);

        if (push && !pop_a)      count_a_d = count_a_q + CW'(1);
        else if (!push && pop_a) count_a_d = count_a_q - CW'(1);
        if (push && !pop_b)      count_b_d = count_b_q + CW'(1);
        else if (!push && pop_b) count_b_d = count_b_q - CW'(1);
    end

    // Pointer and occupancy registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_a_q <= '0;
            rd_ptr_a_q <= '0;
            count_a_q  <= '0;
            wr_ptr_b_q <= '0;
            rd_ptr_b_q <= '0;
            count_b_q  <= '0;
        end else begin
            wr_ptr_a_q <= wr_ptr_a_d;
            rd_ptr_a_q <= rd_ptr_a_d;
            count_a_q  <= count_a_d;
            wr_ptr_b_q <= wr_ptr_b_d;
            rd_ptr_b_q <= rd_ptr_b_d;
            count_b_q  <= count_b_d;
        end
    end

    // Storage: both fields of a beat land in the same cycle; cleared on reset
    // so the outputs read zero until the first post-reset beat
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_a_q[i] <= '0;
                mem_b_q[i] <= '0;
            end
        end else if (push) begin
            mem_a_q[wr_ptr_a_q] <= bus.s_axis_atdata;
            mem_b_q[wr_ptr_b_q] <= bus.s_axis_btdata;
        end
    end

`ifdef SPLIT2_STALL_CNT_EN
    logic [31:0] stall_q, stall_d;

    // Saturating count of cycles where a beat is offered but refused
    always_comb begin
        stall_d = stall_q;
        if (bus.s_axis_tvalid && !bus.s_axis_tready && rst && (stall_q != 32'hFFFF_FFFF))
            stall_d = stall_q + 32'd1;
    end

    // Stall counter register
    always_ff @(posedge clk) begin
        if (!rst) stall_q <= '0;
        else      stall_q <= stall_d;
    end

    assign stall_count = stall_q;
`endif

endmodule

// File: tb/tb_split2.sv
// tb/tb_split2.sv - directed self-checking bench for split2
module tb_split2;

    logic clk;
    logic rst;
`ifdef SPLIT2_STALL_CNT_EN
    logic [31:0] stall_count;
`endif

    int checks = 0;
    int errors = 0;

    split2_if #(.ADW(24), .BDW(18)) bus ();

    split2 #(.ADW(24), .BDW(18), .DEPTH(4)) dut (
        .clk         (clk),
        .rst         (rst),
`ifdef SPLIT2_STALL_CNT_EN
        .stall_count (stall_count),
`endif
        .bus         (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b0;
        bus.s_axis_atdata  = '0;
        bus.s_axis_btdata  = '0;
        bus.s_axis_tvalid  = 1'b0;
        bus.m_axis_atready = 1'b0;
        bus.m_axis_btready = 1'b0;

        // reset state
        tick();
        tick();
        chk("rst_tready", 32'(bus.s_axis_tready), 0);
        chk("rst_avalid", 32'(bus.m_axis_atvalid), 0);
        chk("rst_bvalid", 32'(bus.m_axis_btvalid), 0);
        chk("rst_adata", 32'(bus.m_axis_atdata), 0);
        chk("rst_bdata", 32'(bus.m_axis_btdata), 0);
        rst = 1'b1;
        #1;
        chk("post_rst_tready", 32'(bus.s_axis_tready), 1);

        // basic pass-through, no same-cycle bypass
        bus.m_axis_atready = 1'b1;
        bus.m_axis_btready = 1'b1;
        bus.s_axis_atdata = 24'h000001;
        bus.s_axis_btdata = 18'h00002;
        bus.s_axis_tvalid = 1'b1;
        #1;
        chk("basic_nobypass_a", 32'(bus.m_axis_atvalid), 0);
        chk("basic_nobypass_b", 32'(bus.m_axis_btvalid), 0);
        tick();
        bus.s_axis_tvalid = 1'b0;
        #1;
        chk("basic_avalid", 32'(bus.m_axis_atvalid), 1);
        chk("basic_bvalid", 32'(bus.m_axis_btvalid), 1);
        chk("basic_adata", 32'(bus.m_axis_atdata), 32'h1);
        chk("basic_bdata", 32'(bus.m_axis_btdata), 32'h2);
        tick();
        chk("basic_avalid_fall", 32'(bus.m_axis_atvalid), 0);
        chk("basic_bvalid_fall", 32'(bus.m_axis_btvalid), 0);

        // skewed drain: A runs, B stalls until FIFO B fills
        bus.m_axis_atready = 1'b1;
        bus.m_axis_btready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus.s_axis_atdata = 24'(i);
            bus.s_axis_btdata = 18'(32'h100 + i);
            bus.s_axis_tvalid = 1'b1;
            #1;
            chk("skew_tready", 32'(bus.s_axis_tready), 1);
            if (i > 0) chk("skew_adata", 32'(bus.m_axis_atdata), 32'(i - 1));
            tick();
        end
        bus.s_axis_tvalid = 1'b0;
        #1;
        chk("skew_full_tready", 32'(bus.s_axis_tready), 0);
        chk("skew_adata3", 32'(bus.m_axis_atdata), 32'h3);
        chk("skew_bvalid", 32'(bus.m_axis_btvalid), 1);
        tick();
        tick();
        chk("skew_a_empty", 32'(bus.m_axis_atvalid), 0);
        chk("skew_bvalid_hold", 32'(bus.m_axis_btvalid), 1);
        chk("skew_bdata_hold", 32'(bus.m_axis_btdata), 32'h100);
        chk("skew_tready_hold", 32'(bus.s_axis_tready), 0);
        bus.m_axis_btready = 1'b1;
        #1;
        chk("skew_tready_on_pop", 32'(bus.s_axis_tready), 0);
        tick();
        chk("skew_tready_after_pop", 32'(bus.s_axis_tready), 1);
        chk("skew_bdata1", 32'(bus.m_axis_btdata), 32'h101);
        tick();
        chk("skew_bdata2", 32'(bus.m_axis_btdata), 32'h102);
        tick();
        chk("skew_bdata3", 32'(bus.m_axis_btdata), 32'h103);
        tick();
        chk("skew_b_empty", 32'(bus.m_axis_btvalid), 0);

        // streaming: 64 back-to-back beats, no bubbles after the first
        for (int c = 0; c <= 64; c++) begin
            bus.s_axis_tvalid = (c < 64);
            bus.s_axis_atdata = 24'(32'h1000 + c);
            bus.s_axis_btdata = 18'(32'h2000 + c);
            #1;
            if (c < 64) chk("stream_tready", 32'(bus.s_axis_tready), 1);
            if (c > 0) begin
                chk("stream_avalid", 32'(bus.m_axis_atvalid), 1);
                chk("stream_bvalid", 32'(bus.m_axis_btvalid), 1);
                chk("stream_adata", 32'(bus.m_axis_atdata), 32'(32'h1000 + c - 1));
                chk("stream_bdata", 32'(bus.m_axis_btdata), 32'(32'h2000 + c - 1));
            end
            tick();
        end
        chk("stream_a_done", 32'(bus.m_axis_atvalid), 0);
        chk("stream_b_done", 32'(bus.m_axis_btvalid), 0);

        // full FIFO A popped in the same cycle as an offered beat
        bus.m_axis_atready = 1'b0;
        bus.m_axis_btready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus.s_axis_atdata = 24'(32'h10 + i);
            bus.s_axis_btdata = 18'(32'h20 + i);
            bus.s_axis_tvalid = 1'b1;
            tick();
        end
        bus.s_axis_atdata = 24'h000055;
        bus.s_axis_btdata = 18'h00066;
        bus.m_axis_atready = 1'b1;
        #1;
        chk("fullpop_tready", 32'(bus.s_axis_tready), 0);
        chk("fullpop_adata", 32'(bus.m_axis_atdata), 32'h10);
        tick();
        chk("fullpop_tready_next", 32'(bus.s_axis_tready), 1);
        chk("fullpop_adata1", 32'(bus.m_axis_atdata), 32'h11);
        chk("fullpop_no_push_b", 32'(bus.m_axis_btvalid), 0);
        tick();
        bus.s_axis_tvalid = 1'b0;
        #1;
        chk("fullpop_adata2", 32'(bus.m_axis_atdata), 32'h12);
        chk("fullpop_bvalid", 32'(bus.m_axis_btvalid), 1);
        chk("fullpop_bdata", 32'(bus.m_axis_btdata), 32'h66);
        tick();
        chk("fullpop_adata3", 32'(bus.m_axis_atdata), 32'h13);
        chk("fullpop_b_empty", 32'(bus.m_axis_btvalid), 0);
        tick();
        chk("fullpop_adata_new", 32'(bus.m_axis_atdata), 32'h55);
        tick();
        chk("fullpop_a_empty", 32'(bus.m_axis_atvalid), 0);

        // reset mid-stream with 3 beats buffered
        bus.m_axis_atready = 1'b0;
        bus.m_axis_btready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus.s_axis_atdata = 24'(32'h77 + i);
            bus.s_axis_btdata = 18'(32'h88 + i);
            bus.s_axis_tvalid = 1'b1;
            tick();
        end
        bus.s_axis_tvalid = 1'b0;
        rst = 1'b0;
        #1;
        chk("midrst_tready_comb", 32'(bus.s_axis_tready), 0);
        tick();
        chk("midrst_avalid", 32'(bus.m_axis_atvalid), 0);
        chk("midrst_bvalid", 32'(bus.m_axis_btvalid), 0);
        chk("midrst_adata", 32'(bus.m_axis_atdata), 0);
        chk("midrst_bdata", 32'(bus.m_axis_btdata), 0);
        chk("midrst_tready", 32'(bus.s_axis_tready), 0);
        rst = 1'b1;
        bus.m_axis_atready = 1'b1;
        bus.m_axis_btready = 1'b1;
        bus.s_axis_atdata = 24'hABCDEF;
        bus.s_axis_btdata = 18'h01234;
        bus.s_axis_tvalid = 1'b1;
        tick();
        bus.s_axis_tvalid = 1'b0;
        #1;
        chk("midrst_first_avalid", 32'(bus.m_axis_atvalid), 1);
        chk("midrst_first_adata", 32'(bus.m_axis_atdata), 32'hABCDEF);
        chk("midrst_first_bdata", 32'(bus.m_axis_btdata), 32'h1234);
        tick();
        chk("midrst_drained", 32'(bus.m_axis_atvalid), 0);

`ifdef SPLIT2_STALL_CNT_EN
        // stall counter: 4 beats fill B, then 6 refused cycles
        rst = 1'b0;
        tick();
        chk("stall_rst", stall_count, 0);
        rst = 1'b1;
        bus.m_axis_atready = 1'b1;
        bus.m_axis_btready = 1'b0;
        bus.s_axis_tvalid = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        bus.s_axis_tvalid = 1'b0;
        #1;
        chk("stall_count6", stall_count, 6);
        rst = 1'b0;
        tick();
        chk("stall_clear", stall_count, 0);
        rst = 1'b1;
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/split2.md
# split2

Stream fork: accepts one AXI-Stream beat carrying a paired A/B payload and delivers the A field and the B field on two independent output streams. Each output has its own DEPTH-entry FIFO, so one consumer can run up to DEPTH beats ahead of the other. Used downstream of paired-payload producers, such as dual-channel samplers or a pair join, to feed consumers that do not run in lockstep.

## Interface
- ADW, 24, width of the A field
- BDW, 18, width of the B field
- DEPTH, 4, entries per output FIFO; power of two, at least 2
- clk  in  1  clock; all logic is on the rising edge
- rst  in  1  one clock; reset is synchronous and active-low
- s_axis_atdata  in  ADW  input A field
- s_axis_btdata  in  BDW  input B field
- s_axis_tvalid  in  1  input beat valid
- s_axis_tready  out  1  input beat accepted when high together with tvalid
- m_axis_atdata  out  ADW  A output data
- m_axis_atvalid  out  1  A output valid
- m_axis_atready  in  1  A output ready
- m_axis_btdata  out  BDW  B output data
- m_axis_btvalid  out  1  B output valid
- m_axis_btready  in  1  B output ready
- stall_count  out  32  present only with SPLIT2_STALL_CNT_EN; see Configuration

## Operation
- Two FIFOs, A and B, each with: DEPTH-entry memory, write pointer and read pointer of log2(DEPTH) bits with natural wrap, occupancy count of log2(DEPTH)+1 bits.
- Definitions:
  - full_x = (count_x == DEPTH)
  - empty_x = (count_x == 0)
  - push = s_axis_tvalid && s_axis_tready
  - pop_x = m_axis_xtvalid && m_axis_xtready
- s_axis_tready = rst && !full_a && !full_b.
  - It depends only on registered state and rst, never on m_axis_*tready.
- On push: A field is written to FIFO A and B field to FIFO B in the same cycle; both write pointers advance.
  - A beat is never split: either both fields are stored or neither is.
- m_axis_xtvalid = !empty_x. m_axis_xtdata = mem_x[rd_ptr_x].
  - Data is held stable while valid is high and ready is low.
- On pop_x: rd_ptr_x advances.
- Count update per FIFO:
  - push and no pop: +1
  - pop and no push: -1
  - push and pop in the same cycle: unchanged, both pointers advance
- The A and B FIFOs drain independently. The occupancy difference between them is bounded by DEPTH.
- Output ordering per stream equals input order.

## Timing
- Latency: a beat accepted at edge N is presented at both outputs after edge N (visible in cycle N+1) when the respective FIFO was empty.
- Throughput: 1 beat/cycle sustained when both consumers hold ready high.
- Full boundary:
  - With count_x == DEPTH, s_axis_tready is 0 even if pop_x occurs that cycle.
  - tready rises the cycle after the pop.
- Empty boundary: a push into an empty FIFO does not bypass to the output in the same cycle.
- Reset (rst low at a rising edge):
  - Pointers and counts clear to 0.
  - Memories clear to 0.
  - m_axis_atvalid and m_axis_btvalid are 0; m_axis_atdata and m_axis_btdata are 0.
  - s_axis_tready is 0 combinationally while rst is low.
- Reset mid-operation: all buffered beats are discarded. No partial beat survives. The first post-reset output is the first post-reset input.

## Configuration
- SPLIT2_STALL_CNT_EN defined:
  - stall_count port exists.
  - 32-bit counter increments every cycle with s_axis_tvalid && !s_axis_tready && rst.
  - Saturates at 0xFFFFFFFF. Clears to 0 on reset.
- SPLIT2_STALL_CNT_EN undefined: port and counter are absent. All other behaviour is identical.

## Test plan
- Basic pass-through:
  - Stimulus: after reset, push a=0x000001 / b=0x00002, both readies held high.
  - Required: both valids rise one cycle after the push, data matches, and both valids fall after the pop.
- Skewed drain (DEPTH=4):
  - Stimulus: atready=1, btready=0, push 4 beats a=i / b=0x100+i.
  - Required: A outputs 0,1,2,3; btvalid stays 1; s_axis_tready=0 after the 4th push.
  - Then assert btready=1. Required: B outputs 0x100..0x103 in order, and tready returns 1 the cycle after the first B pop.
- Streaming: both readies high, 64 back-to-back beats. Required: 64 beats on each output with no bubbles after the first, in order.
- Full with simultaneous pop:
  - Stimulus: FIFO A full and popped in the same cycle as s_axis_tvalid=1.
  - Required: no push that cycle; count_a becomes 3; the push happens the next cycle.
- Reset mid-stream:
  - Stimulus: 3 beats buffered, drive rst low for 1 cycle.
  - Required: both valids are 0, data is 0, tready is 0 during reset; the next input beat 0xABCDEF / 0x1234 is the first beat out.
- Stall counter (SPLIT2_STALL_CNT_EN defined):
  - Stimulus: btready=0 and 10 cycles of tvalid=1 with DEPTH=4.
  - Required: stall_count reads 6; it reads 0 after reset.
